// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters.
// Each winner holds gnt while q runs 0..len, then gets a one-cycle done pulse.
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CW-1:0]    q
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   win, win_n;
  logic [CW-1:0]   len_r, len_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [CW-1:0]   q_n;

  logic [CW-1:0]   len_a [NREQ];
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   pnext;
  int              idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_a[i] = len[i*CW +: CW];
  end

  // Scan offsets from high to low so the nearest request past ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
    pnext = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    len_n   = len_r;
    gnt_n   = gnt;
    done_n  = '0;
    q_n     = q;
    unique case (state)
      S_IDLE: begin
        gnt_n = '0;
        q_n   = '0;
        if (found) begin
          state_n     = S_RUN;
          gnt_n[pick] = 1'b1;
          win_n       = pick;
          len_n       = len_a[pick];
          ptr_n       = pnext;
        end
      end
      S_RUN: begin
        // Abort outranks terminal count.
        if (!req[win]) begin
          state_n = S_IDLE;
          gnt_n   = '0;
          q_n     = '0;
        end else if (q == len_r) begin
          state_n     = S_DONE;
          gnt_n       = '0;
          done_n[win] = 1'b1;
          q_n         = '0;
        end else begin
          q_n = q + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        q_n     = '0;
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
        q_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      win   <= '0;
      len_r <= '0;
      gnt   <= '0;
      done  <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      win   <= win_n;
      len_r <= len_n;
      gnt   <= gnt_n;
      done  <= done_n;
      q     <= q_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
